exmem_pipl: RTL and testbench
=============================

# exmem_pipl

Execute stage and EX/MEM pipeline register. Consumes the 153-bit ID/EX bundle produced by `idex_pipl`, unpacks it, executes the ALU operation, and registers the result plus the forwarded memory/writeback controls into a 76-bit EX/MEM bundle for the MEM stage. A `stall`/`busy` handshake and a `flush` input keep it in lockstep with the pipeline. An optional iterative multiplier (see Configuration) is the multi-cycle path.

## Interface
- No parameters. Widths are fixed by the package.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `idex_reg` in 153: ID/EX bundle. Field bits, LSB first:
  - reg_wr[0], alu_src[1], mem_wr[2], mem_to_rgs[3], mem_rd[4], brnch[5]
  - alu_op[9:6], rdb[41:10], rda[73:42], im_gen[105:74]
  - wa[110:106], rb[115:111], ra[120:116], instruction[152:121]
- `idex_valid` in 1: `idex_reg` holds a real instruction.
- `stall` in 1: MEM stage cannot accept; hold `exmem_reg`.
- `flush` in 1: kill the instruction in EX and in EX/MEM.
- `busy` out 1: EX cannot accept a new instruction this cycle.
- `exmem_reg` out 76. Field bits, LSB first:
  - valid[0], reg_wr[1], mem_wr[2], mem_to_rgs[3], mem_rd[4], brnch[5], zero[6]
  - wa[11:7], store_data[43:12] (rdb), alu_result[75:44]
- `branch_taken` out 1: registered `brnch & zero & valid` of `exmem_reg`.

## Operation
- Operand A = rda. Operand B = im_gen if alu_src, else rdb.
- alu_op codes, all 32-bit with wrap-around:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR
  - 0111 SLT: signed compare, result 1 or 0
  - 1000 MUL: only with the macro; see Configuration
  - Any other code: result 0
- zero = (alu_result == 0).
- Accept condition: `idex_valid & ~busy & ~stall & ~flush`. An invalid accept loads a bubble (valid=0, all controls 0, other fields don't-care but zeroed).
- FSM states:
  - IDLE: single-cycle ops load `exmem_reg` on accept. MUL accept latches operands and controls, then goes to MUL.
  - MUL: one shift-add step per cycle, 5-bit counter; 31 → DONE.
  - DONE: loads `exmem_reg` with the low 32 product bits when `~stall`, then goes to IDLE.
- `busy` = (state != IDLE), combinational from state.
- `flush` has priority over everything:
  - Next edge: `exmem_reg.valid`=0 and `branch_taken`=0.
  - FSM → IDLE and the counter clears.
  - The accept is suppressed.
- `stall` without flush:
  - `exmem_reg` and `branch_taken` hold.
  - MUL iterations continue; DONE waits.
- Reset: `exmem_reg`=0, `branch_taken`=0, `busy`=0, FSM IDLE, counter 0. Reset mid-multiply discards the operation.

## Timing
- Single-cycle ops: `idex_reg` sampled at edge N, result visible after edge N. Latency is 1.
- MUL, no stall:
  - Accept at edge N.
  - `busy`=1 from after edge N until after edge N+33.
  - Result loads at edge N+33; `busy`=0 after that edge.
- `branch_taken` updates on the same edge as `exmem_reg`.
- No combinational path from `idex_reg` to any output. `busy` depends on state only.

## Configuration
- `EXMEM_MUL_EN`:
  - Defined: MUL op and the IDLE/MUL/DONE FSM are compiled in.
  - Undefined: alu_op 1000 yields 0 in one cycle, `busy` is tied 0, and no FSM or counter is built.

## Structure
- Shared package `exmem_pkg`:
  - Bundle widths (153, 76) and all field LSB/MSB constants for both bundles.
  - alu_op code constants and the FSM state typedef.
  - `idex_pipl` imports the same offsets.
- Sub-module `exmem_alu`: combinational ALU for the single-cycle ops, plus zero flag. The FSM and registers stay in `exmem_pipl`.

## Test plan
- ADD: rda=5, rdb=7, alu_src=0, alu_op=0010, reg_wr=1, wa=3 → after 1 edge: alu_result=12, wa=3, reg_wr=1, valid=1, zero=0.
- SUB branch: rda=rdb=0x1234, alu_op=0110, brnch=1 → zero=1, branch_taken=1. SLT with rda=0xFFFFFFFF, imm=1, alu_src=1 → result 1.
- Stall: issue ADD, then assert `stall` 3 cycles with a new valid input → `exmem_reg` unchanged for 3 cycles; the new op loads 1 edge after `stall` drops.
- Flush: valid ADD in EX/MEM plus `flush` → next edge valid=0, branch_taken=0. Unknown alu_op 1111 → result 0, zero=1.
- MUL (with macro): 0xFFFF × 0x10001 → `busy` high 33 cycles, result 0xFFFFFFFF. Repeat with `flush` at iteration 10 → IDLE, no valid result. Repeat with reset asserted mid-run → all outputs 0.
- MUL (without macro): alu_op 1000, rda=3, rdb=4 → result 0 after 1 edge, `busy` never asserts.

Source files
------------

// File: rtl/exmem_pkg.sv
// Shared widths, bundle field offsets, ALU op codes and FSM state type for the EX stage.
// idex_pipl imports the same ID/EX offsets so both ends of the bundle agree.
package exmem_pkg;

    localparam int IDEX_W  = 153;
    localparam int EXMEM_W = 76;
    localparam int XLEN    = 32;

    // ID/EX bundle, LSB first
    localparam int ID_REG_WR     = 0;
    localparam int ID_ALU_SRC    = 1;
    localparam int ID_MEM_WR     = 2;
    localparam int ID_MEM_TO_RGS = 3;
    localparam int ID_MEM_RD     = 4;
    localparam int ID_BRNCH      = 5;
    localparam int ID_ALU_OP_LSB = 6;
    localparam int ID_ALU_OP_MSB = 9;
    localparam int ID_RDB_LSB    = 10;
    localparam int ID_RDB_MSB    = 41;
    localparam int ID_RDA_LSB    = 42;
    localparam int ID_RDA_MSB    = 73;
    localparam int ID_IMM_LSB    = 74;
    localparam int ID_IMM_MSB    = 105;
    localparam int ID_WA_LSB     = 106;
    localparam int ID_WA_MSB     = 110;
    localparam int ID_RB_LSB     = 111;
    localparam int ID_RB_MSB     = 115;
    localparam int ID_RA_LSB     = 116;
    localparam int ID_RA_MSB     = 120;
    localparam int ID_INSTR_LSB  = 121;
    localparam int ID_INSTR_MSB  = 152;

    // EX/MEM bundle, LSB first
    localparam int EX_VALID      = 0;
    localparam int EX_REG_WR     = 1;
    localparam int EX_MEM_WR     = 2;
    localparam int EX_MEM_TO_RGS = 3;
    localparam int EX_MEM_RD     = 4;
    localparam int EX_BRNCH      = 5;
    localparam int EX_ZERO       = 6;
    localparam int EX_WA_LSB     = 7;
    localparam int EX_WA_MSB     = 11;
    localparam int EX_SD_LSB     = 12;
    localparam int EX_SD_MSB     = 43;
    localparam int EX_RES_LSB    = 44;
    localparam int EX_RES_MSB    = 75;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exmem_state_e;

    // Controls that travel from ID/EX into EX/MEM unchanged
    typedef struct packed {
        logic            reg_wr;
        logic            mem_wr;
        logic            mem_to_rgs;
        logic            mem_rd;
        logic            brnch;
        logic [4:0]      wa;
        logic [XLEN-1:0] store_data;
    } exmem_ctrl_t;

    function automatic logic [EXMEM_W-1:0] pack_exmem(input exmem_ctrl_t c,
                                                      input logic [XLEN-1:0] result,
                                                      input logic zero);
        logic [EXMEM_W-1:0] b;
        b = '0;
        b[EX_VALID]               = 1'b1;
        b[EX_REG_WR]              = c.reg_wr;
        b[EX_MEM_WR]              = c.mem_wr;
        b[EX_MEM_TO_RGS]          = c.mem_to_rgs;
        b[EX_MEM_RD]              = c.mem_rd;
        b[EX_BRNCH]               = c.brnch;
        b[EX_ZERO]                = zero;
        b[EX_WA_MSB:EX_WA_LSB]    = c.wa;
        b[EX_SD_MSB:EX_SD_LSB]    = c.store_data;
        b[EX_RES_MSB:EX_RES_LSB]  = result;
        return b;
    endfunction

endpackage

// File: rtl/exmem_if.sv
// Pipeline-facing signals of the EX stage: ID/EX bundle in, EX/MEM bundle out.
interface exmem_if;
    import exmem_pkg::*;

    // Handshake: an ID/EX bundle is taken on a rising edge only when idex_valid=1, busy=0,
    // stall=0 and flush=0; the producer must hold idex_reg/idex_valid while busy is high.
    // stall freezes exmem_reg/branch_taken; flush overrides everything and kills EX and EX/MEM.
    logic [IDEX_W-1:0]  idex_reg;
    logic               idex_valid;
    logic               stall;
    logic               flush;
    logic               busy;
    logic [EXMEM_W-1:0] exmem_reg;
    logic               branch_taken;
    exmem_state_e       dbg_state;

    modport master (
        output idex_reg, idex_valid, stall, flush,
        input  busy, exmem_reg, branch_taken, dbg_state
    );

    modport slave (
        input  idex_reg, idex_valid, stall, flush,
        output busy, exmem_reg, branch_taken, dbg_state
    );
endinterface

// File: rtl/exmem_alu.sv
// Combinational ALU for the single-cycle ops plus zero flag; unknown codes (and MUL) give 0.
module exmem_alu
    import exmem_pkg::*;
(
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_ADD: result = op_a + op_b;
            ALU_SUB: result = op_a - op_b;
            ALU_NOR: result = ~(op_a | op_b);
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/exmem_pipl.sv
// Execute stage and EX/MEM pipeline register with stall/flush/busy handshake.
// Define EXMEM_MUL_EN to build the iterative shift-add multiplier (IDLE/MUL/DONE FSM).
module exmem_pipl
    import exmem_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    exmem_if.slave   bus
);

    logic [IDEX_W-1:0]  idex;
    logic [3:0]         alu_op;
    logic [XLEN-1:0]    rda;
    logic [XLEN-1:0]    rdb;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    op_b;
    logic [XLEN-1:0]    alu_result;
    logic               alu_zero;
    exmem_ctrl_t        ctrl_in;
    logic [EXMEM_W-1:0] exmem_q;
    logic [EXMEM_W-1:0] exmem_nx;
    logic               bt_q;
    logic               unused_fields;

    assign idex   = bus.idex_reg;
    assign alu_op = idex[ID_ALU_OP_MSB:ID_ALU_OP_LSB];
    assign rda    = idex[ID_RDA_MSB:ID_RDA_LSB];
    assign rdb    = idex[ID_RDB_MSB:ID_RDB_LSB];
    assign imm    = idex[ID_IMM_MSB:ID_IMM_LSB];
    assign op_b   = idex[ID_ALU_SRC] ? imm : rdb;

    assign ctrl_in.reg_wr     = idex[ID_REG_WR];
    assign ctrl_in.mem_wr     = idex[ID_MEM_WR];
    assign ctrl_in.mem_to_rgs = idex[ID_MEM_TO_RGS];
    assign ctrl_in.mem_rd     = idex[ID_MEM_RD];
    assign ctrl_in.brnch      = idex[ID_BRNCH];
    assign ctrl_in.wa         = idex[ID_WA_MSB:ID_WA_LSB];
    assign ctrl_in.store_data = rdb;

    // ra/rb/instruction ride along for the hazard unit and debug, not used in EX
    assign unused_fields = ^idex[ID_INSTR_MSB:ID_RB_LSB];

    exmem_alu u_alu (
        .alu_op (alu_op),
        .op_a   (rda),
        .op_b   (op_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exmem_q <= '0;
            bt_q    <= 1'b0;
        end else begin
            exmem_q <= exmem_nx;
            bt_q    <= exmem_nx[EX_BRNCH] & exmem_nx[EX_ZERO] & exmem_nx[EX_VALID];
        end
    end

    assign bus.exmem_reg    = exmem_q;
    assign bus.branch_taken = bt_q;

`ifdef EXMEM_MUL_EN
    exmem_state_e    state_q;
    exmem_state_e    state_nx;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] mul_a_q;
    logic [XLEN-1:0] mul_b_q;
    logic [XLEN-1:0] mul_acc_q;
    exmem_ctrl_t     mul_ctrl_q;
    logic            mul_start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_nx;
    end

    // While the multiplier grinds, unstalled cycles push bubbles so MEM never sees a repeat
    always_comb begin
        state_nx  = state_q;
        exmem_nx  = exmem_q;
        mul_start = 1'b0;
        if (bus.flush) begin
            state_nx = ST_IDLE;
            exmem_nx = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.stall) begin
                        if (bus.idex_valid && alu_op == ALU_MUL) begin
                            mul_start = 1'b1;
                            state_nx  = ST_MUL;
                            exmem_nx  = '0;
                        end else if (bus.idex_valid) begin
                            exmem_nx = pack_exmem(ctrl_in, alu_result, alu_zero);
                        end else begin
                            exmem_nx = '0;
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt_q == 5'd31) state_nx = ST_DONE;
                    if (!bus.stall)     exmem_nx = '0;
                end
                ST_DONE: begin
                    if (!bus.stall) begin
                        exmem_nx = pack_exmem(mul_ctrl_q, mul_acc_q, mul_acc_q == '0);
                        state_nx = ST_IDLE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_acc_q  <= '0;
            mul_ctrl_q <= '0;
        end else if (bus.flush) begin
            cnt_q <= '0;
        end else if (mul_start) begin
            cnt_q      <= '0;
            mul_a_q    <= rda;
            mul_b_q    <= op_b;
            mul_acc_q  <= '0;
            mul_ctrl_q <= ctrl_in;
        end else if (state_q == ST_MUL) begin
            mul_acc_q <= mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
            mul_a_q   <= mul_a_q << 1;
            mul_b_q   <= mul_b_q >> 1;
            cnt_q     <= cnt_q + 5'd1;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;
`else
    always_comb begin
        exmem_nx = exmem_q;
        if (bus.flush)       exmem_nx = '0;
        else if (!bus.stall) exmem_nx = bus.idex_valid ? pack_exmem(ctrl_in, alu_result, alu_zero) : '0;
    end

    assign bus.busy      = 1'b0;
    assign bus.dbg_state = ST_IDLE;
`endif

endmodule

// File: tb/tb_exmem_pipl.sv
// Directed bench for exmem_pipl: bundle-level model with expected queue plus literal checks.
module tb_exmem_pipl;

`ifdef EXMEM_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    exmem_if bus ();

    exmem_pipl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [152:0] mk_idex(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] imm, input logic src, input logic rw,
                                             input logic mw, input logic br, input logic [4:0] wa);
        logic [152:0] v;
        v           = '0;
        v[0]        = rw;
        v[1]        = src;
        v[2]        = mw;
        v[3]        = 1'b0;
        v[4]        = 1'b0;
        v[5]        = br;
        v[9:6]      = op;
        v[41:10]    = b;
        v[73:42]    = a;
        v[105:74]   = imm;
        v[110:106]  = wa;
        v[152:121]  = 32'hDEAD_BEEF;
        return v;
    endfunction

    // model: EX/MEM bundle a valid instruction must produce, from the ISA rules
    function automatic logic [75:0] model_bundle(input logic [152:0] v);
        logic [31:0] a, b, r;
        a = v[73:42];
        b = v[1] ? v[105:74] : v[41:10];
        case (v[9:6])
            4'h0:    r = a & b;
            4'h1:    r = a | b;
            4'h2:    r = a + b;
            4'h6:    r = a - b;
            4'hC:    r = ~(a | b);
            4'h7:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8:    r = MUL_ON ? a * b : 32'd0;
            default: r = 32'd0;
        endcase
        return {r, v[41:10], v[110:106], (r == 32'd0), v[5], v[4], v[3], v[2], v[0], 1'b1};
    endfunction

    logic [77:0]  exp_q[$];
    logic [75:0]  m_exmem;
    logic [75:0]  m_mul_bundle;
    bit           m_pending;
    int           m_steps;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_exmem   = '0;
            m_pending = 1'b0;
            m_steps   = 0;
        end else if (bus.flush) begin
            m_pending = 1'b0;
            m_exmem   = '0;
        end else if (m_pending) begin
            if (m_steps > 0) begin
                m_steps--;
                if (!bus.stall) m_exmem = '0;
            end else if (!bus.stall) begin
                m_exmem   = m_mul_bundle;
                m_pending = 1'b0;
            end
        end else if (!bus.stall) begin
            if (bus.idex_valid && MUL_ON && bus.idex_reg[9:6] == 4'h8) begin
                m_pending    = 1'b1;
                m_steps      = 32;
                m_exmem      = '0;
                m_mul_bundle = model_bundle(bus.idex_reg);
            end else if (bus.idex_valid) begin
                m_exmem = model_bundle(bus.idex_reg);
            end else begin
                m_exmem = '0;
            end
        end
        exp_q.push_back({m_pending, m_exmem[5] & m_exmem[6] & m_exmem[0], m_exmem});
    end

    // scoreboard compare, away from the active edge
    always @(negedge clock) begin
        logic [77:0] e;
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                check("exp_q_empty", 76'd0, 76'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_exmem_reg", bus.exmem_reg, e[75:0]);
                check("sb_branch_taken", {75'd0, bus.branch_taken}, {75'd0, e[76]});
                check("sb_busy", {75'd0, bus.busy}, {75'd0, e[77]});
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [152:0] v);
        bus.idex_valid = vld;
        bus.idex_reg   = v;
    endtask

    task automatic chk_res(input string name, input logic [31:0] exp);
        check(name, {44'd0, bus.exmem_reg[75:44]}, {44'd0, exp});
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        check(name, {75'd0, act}, {75'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by 200000 time units");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int g;
        reset          = 1'b0;
        bus.idex_reg   = '0;
        bus.idex_valid = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_exmem", bus.exmem_reg, 76'd0);
        chk_bit("rst_bt", bus.branch_taken, 1'b0);
        chk_bit("rst_busy", bus.busy, 1'b0);
        reset = 1'b1;
        tick();

        // ADD 5+7, wa=3
        drive(1'b1, mk_idex(4'b0010, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3));
        tick();
        chk_res("add_result", 32'd12);
        check("add_wa", {71'd0, bus.exmem_reg[11:7]}, 76'd3);
        chk_bit("add_reg_wr", bus.exmem_reg[1], 1'b1);
        chk_bit("add_valid", bus.exmem_reg[0], 1'b1);
        chk_bit("add_zero", bus.exmem_reg[6], 1'b0);

        // SUB equal operands on a branch
        drive(1'b1, mk_idex(4'b0110, 32'h1234, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0));
        tick();
        chk_bit("sub_zero", bus.exmem_reg[6], 1'b1);
        chk_bit("sub_bt", bus.branch_taken, 1'b1);

        // SLT -1 < imm 1
        drive(1'b1, mk_idex(4'b0111, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4));
        tick();
        chk_res("slt_result", 32'd1);
        chk_bit("slt_bt_clear", bus.branch_taken, 1'b0);

        // unknown op and NOR
        drive(1'b1, mk_idex(4'b1111, 32'd9, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1));
        tick();
        chk_res("unk_result", 32'd0);
        chk_bit("unk_zero", bus.exmem_reg[6], 1'b1);
        drive(1'b1, mk_idex(4'b1100, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2));
        tick();
        chk_res("nor_result", 32'h0F0F_F0F0);
        check("nor_store_data", {44'd0, bus.exmem_reg[43:12]}, 76'h0F0F);

        // stall holds EX/MEM while a new op waits
        drive(1'b1, mk_idex(4'b0010, 32'd100, 32'd23, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5));
        tick();
        chk_res("stall_pre", 32'd123);
        drive(1'b1, mk_idex(4'b0001, 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6));
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_res("stall_hold", 32'd123);
        end
        bus.stall = 1'b0;
        tick();
        chk_res("stall_release", 32'hFF);

        // flush kills a taken branch
        drive(1'b1, mk_idex(4'b0110, 32'h1234, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0));
        tick();
        chk_bit("flush_pre_bt", bus.branch_taken, 1'b1);
        drive(1'b1, mk_idex(4'b0010, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7));
        bus.flush = 1'b1;
        tick();
        chk_bit("flush_valid", bus.exmem_reg[0], 1'b0);
        chk_bit("flush_bt", bus.branch_taken, 1'b0);
        bus.flush = 1'b0;
        drive(1'b0, '0);
        tick();
        chk_bit("bubble_valid", bus.exmem_reg[0], 1'b0);

`ifdef EXMEM_MUL_EN
        // full multiply
        drive(1'b1, mk_idex(4'b1000, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9));
        tick();
        drive(1'b0, '0);
        busy_cnt = 0;
        g = 0;
        while (bus.busy && g < 100) begin
            busy_cnt++;
            g++;
            tick();
        end
        check("mul_busy_cycles", 76'(busy_cnt), 76'd33);
        chk_res("mul_result", 32'hFFFF_FFFF);
        chk_bit("mul_valid", bus.exmem_reg[0], 1'b1);
        tick();

        // flush mid-multiply
        drive(1'b1, mk_idex(4'b1000, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9));
        tick();
        drive(1'b0, '0);
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk_bit("mulflush_busy", bus.busy, 1'b0);
        chk_bit("mulflush_valid", bus.exmem_reg[0], 1'b0);
        repeat (40) tick();
        chk_bit("mulflush_late_valid", bus.exmem_reg[0], 1'b0);

        // reset mid-multiply
        drive(1'b1, mk_idex(4'b1000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9));
        tick();
        drive(1'b0, '0);
        repeat (5) tick();
        #1 reset = 1'b0;
        #1;
        check("mulrst_exmem", bus.exmem_reg, 76'd0);
        chk_bit("mulrst_busy", bus.busy, 1'b0);
        chk_bit("mulrst_bt", bus.branch_taken, 1'b0);
        tick();
        reset = 1'b1;
        repeat (40) tick();
        chk_bit("mulrst_late_valid", bus.exmem_reg[0], 1'b0);
`else
        // MUL code without the multiplier is an unknown op
        drive(1'b1, mk_idex(4'b1000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9));
        tick();
        chk_res("nomul_result", 32'd0);
        chk_bit("nomul_valid", bus.exmem_reg[0], 1'b1);
        chk_bit("nomul_busy", bus.busy, 1'b0);
        drive(1'b0, '0);
        tick();
        chk_bit("nomul_busy_after", bus.busy, 1'b0);
`endif

        tick();
        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
